// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - memory-stage data responder with posted-store write buffer and load forwarding
module data_mem_responder #(
  parameter int ADDR_W   = 8,
  parameter int WB_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wb_empty
);

  localparam int PW    = $clog2(WB_DEPTH);
  localparam int CW    = PW + 1;
  localparam int DEPTH = 1 << ADDR_W;

  // single-port data array and write-buffer storage (not reset)
  logic [31:0]       mem_q     [DEPTH];
  logic [ADDR_W-1:0] wb_idx_q  [WB_DEPTH];
  logic [31:0]       wb_data_q [WB_DEPTH];
  logic [31:0]       rd_data_q;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_load_q, rsp_load_d;
  logic        fwd_hit_q, fwd_hit_d;
  logic [31:0] fwd_data_q, fwd_data_d;

  logic [ADDR_W-1:0] req_idx;
  logic              addr_err;
  logic              wb_full;
  logic              accept;
  logic              load_ok;
  logic              store_ok;
  logic              drain;

  // request decode, handshake and array-port arbitration (an accepted load owns the port)
  always_comb begin
    req_idx  = req_addr[ADDR_W+1:2];
    addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
    wb_full  = (count_q == CW'(WB_DEPTH));
    accept   = req_valid && !wb_full;
    load_ok  = accept && !req_we && !addr_err;
    store_ok = accept && req_we && !addr_err;
    drain    = !load_ok && (count_q != '0);
  end

  assign req_ready = !wb_full;
  assign wb_empty  = (count_q == '0);

  // forwarding search: walk entries oldest to youngest so the youngest match wins
  always_comb begin
    fwd_hit_d  = 1'b0;
    fwd_data_d = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if ((CW'(i) < count_q) && (wb_idx_q[head_q + PW'(i)] == req_idx)) begin
        fwd_hit_d  = 1'b1;
        fwd_data_d = wb_data_q[head_q + PW'(i)];
      end
    end
  end

  // next-state for buffer pointers and the registered response
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q + CW'(store_ok) - CW'(drain);
    rsp_valid_d = accept;
    rsp_err_d   = accept && addr_err;
    rsp_load_d  = load_ok;
    if (store_ok) begin
      tail_d = tail_q + PW'(1);
    end
    if (drain) begin
      head_d = head_q + PW'(1);
    end
  end

  // control and response registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      fwd_hit_q   <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_load_q  <= rsp_load_d;
      fwd_hit_q   <= fwd_hit_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  // buffer push, head drain into the array, and synchronous array read on a load miss
  always_ff @(posedge clk) begin
    if (store_ok) begin
      wb_idx_q[tail_q]  <= req_idx;
      wb_data_q[tail_q] <= req_wdata;
    end
    if (drain) begin
      mem_q[wb_idx_q[head_q]] <= wb_data_q[head_q];
    end
    if (load_ok && !fwd_hit_d) begin
      rd_data_q <= mem_q[req_idx];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = (rsp_valid_q && rsp_load_q) ? (fwd_hit_q ? fwd_data_q : rd_data_q) : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized and directed bench for data_mem_responder against a queue-based model
module tb_data_mem_responder;

  localparam int ADDR_W   = 8;
  localparam int WB_DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wb_empty;

  data_mem_responder #(.ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wb_empty  (wb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } ent_t;

  // model: memory as seen after drains, plus the ordered list of posted stores
  logic [31:0] arch [256];
  ent_t        pend [$];

  int n_pass;
  int n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // one clock: drive a request, predict the cycle from the rules, check the response
  task automatic step(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    bit          rdy, acc, err, ld_ok, st_ok, had;
    logic [31:0] ld;
    int          idx;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    #1;
    rdy = (pend.size() != WB_DEPTH);
    chk("req_ready", {31'd0, req_ready}, {31'd0, rdy});
    chk("wb_empty", {31'd0, wb_empty}, {31'd0, pend.size() == 0});
    acc   = v && rdy;
    err   = (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != 0);
    idx   = int'(a[ADDR_W+1:2]);
    ld_ok = acc && !we && !err;
    st_ok = acc && we && !err;
    ld    = 32'd0;
    if (ld_ok) begin
      ld = arch[idx];
      foreach (pend[i]) if (pend[i].idx == idx) ld = pend[i].data;
    end
    had = (pend.size() > 0);
    if (st_ok) pend.push_back('{idx, d});
    if (!ld_ok && had) begin
      arch[pend[0].idx] = pend[0].data;
      void'(pend.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, acc});
    if (acc) begin
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, err});
      chk("rsp_rdata", rsp_rdata, ld);
    end
  endtask

  logic [31:0] a;
  logic [31:0] d;
  int          r;

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    @(negedge clk);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("reset wb_empty", {31'd0, wb_empty}, 32'd1);
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;

    // give every array word a known value
    for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 32'(i * 4), $urandom);
    step(1'b0, 1'b0, 32'h0, 32'h0);

    // store, idle, load back from the array
    step(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h10, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);

    // two stores to one word, immediate load forwards the youngest
    step(1'b1, 1'b1, 32'h20, 32'h1111_1111);
    step(1'b1, 1'b1, 32'h20, 32'h2222_2222);
    step(1'b1, 1'b0, 32'h20, 32'h0);
    repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h20, 32'h0);

    // load stream to 0x40 with interleaved stores
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'h40, 32'h0);
      if (i % 2 == 0) step(1'b1, 1'b1, 32'h40 + 32'(4 * (i % 3)), $urandom);
      step(1'b1, 1'b0, 32'h40, 32'h0);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0);

    // misaligned load and out-of-range store have no side effects
    step(1'b1, 1'b0, 32'h0000_0006, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0400, 32'hBAD0_BAD0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h0000_0000, 32'h0);

    // reset with a store still posted
    step(1'b1, 1'b1, 32'h50, 32'h5050_5050);
    step(1'b1, 1'b1, 32'h54, 32'h5454_5454);
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    pend.delete();
    chk("midrun rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrun rsp_rdata", rsp_rdata, 32'd0);
    chk("midrun rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("midrun wb_empty", {31'd0, wb_empty}, 32'd1);
    chk("midrun req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 32'h50, 32'h0);
    step(1'b1, 1'b0, 32'h54, 32'h0);

    // alternating store/load pairs over rotating addresses
    for (int i = 0; i < 16; i++) begin
      a = 32'((i * 4) % 64);
      step(1'b1, 1'b1, a, $urandom);
      step(1'b1, 1'b0, a, 32'h0);
    end

    // random mix including error requests
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (r == 1) a[$urandom_range(10, 31)] = 1'b1;
      d = $urandom;
      step($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, a, d);
    end
    repeat (2) step(1'b0, 1'b0, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
